aes_spi_master: RTL and testbench

- SPI master that feeds one AES job to the AES SPI slave and collects the result.
- A job is 128-bit plaintext plus a 32*Nk-bit key. After a fixed encryption wait it clocks back the 128-bit ciphertext.
- Sits between the host-side control logic and the off-block SPI link. Mode 0 (CPOL=0, CPHA=0), MSB first.

---
 rtl/aes_spi_pkg.sv | 23 ++
 rtl/aes_spi_master_if.sv | 10 +
 rtl/spi_sclk_gen.sv | 40 ++++
 rtl/aes_spi_master.sv | 117 +++++++++++
 tb/tb_aes_spi_master.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/aes_spi_pkg.sv
// Shared definitions for the AES SPI master/slave pair: state encoding,
// frame sizes and counter widths.
package aes_spi_pkg;

  localparam int RX_BITS    = 128;
  localparam int BIT_CNT_W  = 9;
  localparam int DIV_CNT_W  = 8;
  localparam int WAIT_CNT_W = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_TX   = 3'd1;
  localparam state_t ST_WAIT = 3'd2;
  localparam state_t ST_RX   = 3'd3;
  localparam state_t ST_DONE = 3'd4;

  // Plaintext followed by the key, sent as one contiguous frame.
  function automatic int frame_tx_bits(input int nk);
    return 128 + 32 * nk;
  endfunction

endpackage

// File: rtl/aes_spi_master_if.sv
// Four-wire SPI link between the AES SPI master and the AES SPI slave.
interface aes_spi_master_if;
  logic SCLK;
  logic MOSI;
  logic MISO;
  logic CS;

  modport master (output SCLK, output MOSI, output CS, input MISO);
  modport slave  (input SCLK, input MOSI, input CS, output MISO);
endinterface

// File: rtl/spi_sclk_gen.sv
// Mode-0 serial clock divider: SCLK low for CLK_DIV cycles, then high for
// CLK_DIV cycles, while enabled. The rise/fall strobes mark the clk edges
// that toggle SCLK.
module spi_sclk_gen
  import aes_spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  logic [DIV_CNT_W-1:0] cnt;
  logic                 last;

  assign last = (cnt == DIV_CNT_W'(CLK_DIV - 1));
  assign rise = en & last & ~sclk;
  assign fall = en & last & sclk;

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (last) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/aes_spi_master.sv
// SPI master that sends one {plaintext, key} frame to the AES slave, waits
// out the encryption time and shifts the 128-bit ciphertext back in.
module aes_spi_master
  import aes_spi_pkg::*;
#(
  parameter int Nk       = 4,
  parameter int Nr       = 10,
  parameter int CLK_DIV  = 2,
  parameter int ENC_WAIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [127:0]      plaintext,
  input  logic [32*Nk-1:0]  key,
  output logic              busy,
  output logic              done,
  output logic [127:0]      ciphertext,
  aes_spi_master_if.master  spi
);

  localparam int TX_BITS     = frame_tx_bits(Nk);
  localparam int WAIT_CYCLES = ENC_WAIT * 2 * CLK_DIV;

  // Nr only has to agree with the key length; it drives no logic here.
  generate
    if (!(Nk == 4 || Nk == 6 || Nk == 8) || Nr != Nk + 6 || CLK_DIV < 1) begin : g_param_check
      $error("aes_spi_master: unsupported Nk/Nr/CLK_DIV combination");
    end
  endgenerate

  state_t                 state;
  logic                   launch;
  logic [TX_BITS-1:0]     tx_sr;
  logic [RX_BITS-1:0]     rx_sr;
  logic [BIT_CNT_W-1:0]   bit_cnt;
  logic [WAIT_CNT_W-1:0]  wait_cnt;
  logic                   sclk_en;
  logic                   sclk_rise;
  logic                   sclk_fall;

  assign sclk_en  = (state == ST_TX) || (state == ST_RX);
  assign busy     = (state != ST_IDLE);
  assign spi.CS   = !(state inside {ST_TX, ST_WAIT, ST_RX});
  assign spi.MOSI = (state == ST_TX) & tx_sr[TX_BITS-1];

  spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (sclk_en),
    .sclk (spi.SCLK),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      launch     <= 1'b0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      wait_cnt   <= '0;
      done       <= 1'b0;
      ciphertext <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        // The accepted start only captures the job; TX begins one cycle
        // later, and further starts are ignored meanwhile.
        ST_IDLE: begin
          if (launch) begin
            launch  <= 1'b0;
            bit_cnt <= '0;
            state   <= ST_TX;
          end else if (start) begin
            launch <= 1'b1;
            tx_sr  <= {plaintext, key};
          end
        end
        ST_TX: begin
          if (sclk_fall) begin
            tx_sr <= tx_sr << 1;
            if (bit_cnt == BIT_CNT_W'(TX_BITS - 1)) begin
              bit_cnt  <= '0;
              wait_cnt <= '0;
              state    <= ST_WAIT;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt == WAIT_CNT_W'(WAIT_CYCLES - 1)) state <= ST_RX;
          else                                         wait_cnt <= wait_cnt + 1'b1;
        end
        ST_RX: begin
          if (sclk_rise) rx_sr <= {rx_sr[RX_BITS-2:0], spi.MISO};
          // Leave only after the last bit period has fully completed.
          if (sclk_fall) begin
            if (bit_cnt == BIT_CNT_W'(RX_BITS - 1)) begin
              bit_cnt    <= '0;
              ciphertext <= rx_sr;
              done       <= 1'b1;
              state      <= ST_DONE;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_spi_master.sv
// Self-checking bench: two masters (Nk=4/CLK_DIV=2 and Nk=8/CLK_DIV=1), each
// talking to a behavioural slave that records MOSI and returns a chosen result.
module tb_aes_spi_master;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start4 = 1'b0;
  logic         start8 = 1'b0;
  logic [127:0] pt  = '0;
  logic [255:0] key = '0;
  logic         busy4, done4, busy8, done8;
  logic [127:0] ct4, ct8;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  aes_spi_master_if spi4 ();
  aes_spi_master_if spi8 ();

  aes_spi_master #(.Nk(4), .Nr(10), .CLK_DIV(2), .ENC_WAIT(16)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .plaintext(pt), .key(key[127:0]),
    .busy(busy4), .done(done4), .ciphertext(ct4), .spi(spi4.master)
  );

  aes_spi_master #(.Nk(8), .Nr(14), .CLK_DIV(1), .ENC_WAIT(16)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .plaintext(pt), .key(key),
    .busy(busy8), .done(done8), .ciphertext(ct8), .spi(spi8.master)
  );

  // Slave models: count SCLK rises per CS frame, record the first F MOSI
  // bits, then present the response MSB first for the next 128 rises.
  int           edges4 = 0, edges8 = 0;
  logic [383:0] mosi4 = '0, mosi8 = '0;
  logic [127:0] resp4 = '0, resp8 = '0;

  always @(posedge spi4.SCLK or negedge spi4.CS) begin
    if (!spi4.SCLK) begin
      edges4 = 0;
      mosi4  = '0;
    end else if (!spi4.CS) begin
      if (edges4 < 256) mosi4 = {mosi4[382:0], spi4.MOSI};
      edges4++;
    end
  end

  always @(posedge spi8.SCLK or negedge spi8.CS) begin
    if (!spi8.SCLK) begin
      edges8 = 0;
      mosi8  = '0;
    end else if (!spi8.CS) begin
      if (edges8 < 384) mosi8 = {mosi8[382:0], spi8.MOSI};
      edges8++;
    end
  end

  always_comb begin
    spi4.MISO = 1'b0;
    if (edges4 >= 256 && edges4 < 384) spi4.MISO = resp4[7'(383 - edges4)];
  end

  always_comb begin
    spi8.MISO = 1'b0;
    if (edges8 >= 384 && edges8 < 512) spi8.MISO = resp8[7'(511 - edges8)];
  end

  // Link monitors: cycles with CS low, and any cycle with SCLK high while CS high.
  int cs_low4 = 0, cs_low8 = 0, viol4 = 0, viol8 = 0;
  always @(posedge clk) begin
    if (!spi4.CS) cs_low4++;
    if (!spi8.CS) cs_low8++;
    if (spi4.CS && spi4.SCLK) viol4++;
    if (spi8.CS && spi8.SCLK) viol8++;
  end

  task automatic check(input string tag, input logic [383:0] obs, input logic [383:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] rnd256();
    return {rnd128(), rnd128()};
  endfunction

  task automatic set_start(input bit sel, input logic v);
    if (sel) start8 = v;
    else     start4 = v;
  endtask

  // Runs one job and compares against the reference: frame = {p, key} MSB
  // first, result = slave response, timing from bit counts and divider.
  task automatic run_job(input bit sel, input logic [127:0] p, input logic [255:0] k,
                         input logic [127:0] r, input bit poke_busy, input bit poke_hold,
                         input string tag);
    int           n, f, div, cs0, extra;
    bit           seen;
    logic [383:0] exp_frame;
    f         = sel ? 384 : 256;
    div       = sel ? 1 : 2;
    exp_frame = sel ? {p, k} : {128'h0, p, k[127:0]};
    @(negedge clk);
    if (sel) resp8 = r;
    else     resp4 = r;
    pt  = p;
    key = k;
    cs0 = sel ? cs_low8 : cs_low4;
    set_start(sel, 1'b1);
    @(posedge clk);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 4000) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      set_start(sel, 1'b0);
      if (poke_hold && n == 3) begin
        pt  = rnd128();
        key = rnd256();
      end
      if (poke_busy && n == 20) set_start(sel, 1'b1);
      seen = sel ? done8 : done4;
    end
    check({tag, " done latency"}, 384'(n), 384'(1 + (f + 128 + 16) * 2 * div));
    check({tag, " ciphertext"}, sel ? ct8 : ct4, r);
    check({tag, " mosi frame"}, sel ? mosi8 : mosi4, exp_frame);
    check({tag, " rx sclk rises"}, 384'((sel ? edges8 : edges4) - f), 384'(128));
    check({tag, " cs low cycles"}, 384'((sel ? cs_low8 : cs_low4) - cs0),
          384'((f + 16 + 128) * 2 * div));
    if (poke_busy) set_start(sel, 1'b1);
    @(negedge clk);
    set_start(sel, 1'b0);
    check({tag, " done one cycle"}, sel ? done8 : done4, 1'b0);
    if (poke_busy) begin
      extra = 0;
      repeat (40) begin
        @(negedge clk);
        if ((sel ? done8 : done4) || (sel ? busy8 : busy4) || !(sel ? spi8.CS : spi4.CS)) extra++;
      end
      check({tag, " no second job"}, 384'(extra), 384'(0));
      check({tag, " ciphertext held"}, sel ? ct8 : ct4, r);
    end
  endtask

  initial begin
    int wait_n;

    #1;
    check("reset cs4", spi4.CS, 1'b1);
    check("reset sclk4", spi4.SCLK, 1'b0);
    check("reset mosi4", spi4.MOSI, 1'b0);
    check("reset busy4", busy4, 1'b0);
    check("reset done4", done4, 1'b0);
    check("reset ct4", ct4, 128'h0);
    check("reset cs8", spi8.CS, 1'b1);
    check("reset busy8", busy8, 1'b0);
    check("reset ct8", ct8, 128'h0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    run_job(1'b0, 128'h00112233445566778899aabbccddeeff,
            {128'h0, 128'h000102030405060708090a0b0c0d0e0f},
            128'h69c4e0d86a7b0430d8cdb78070b4c55a, 1'b0, 1'b0, "fips128");

    run_job(1'b0, {1'b1, 126'h0, 1'b1}, 256'h0, rnd128(), 1'b0, 1'b0, "framing");

    run_job(1'b1, 128'h00112233445566778899aabbccddeeff,
            256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
            128'h8ea2b7ca516745bfeafc49904b496089, 1'b0, 1'b0, "fips256");

    for (int i = 0; i < 2; i++) begin
      run_job(1'b0, rnd128(), rnd256(), rnd128(), 1'b0, 1'b0, "rand nk4");
      run_job(1'b1, rnd128(), rnd256(), rnd128(), 1'b0, 1'b0, "rand nk8");
    end

    run_job(1'b0, rnd128(), rnd256(), rnd128(), 1'b1, 1'b0, "start busy");
    run_job(1'b0, rnd128(), rnd256(), rnd128(), 1'b0, 1'b1, "hold");

    // Reset in the middle of RX, then a fresh job.
    @(negedge clk);
    pt     = rnd128();
    key    = rnd256();
    resp4  = rnd128();
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    wait_n = 0;
    while (edges4 < 256 + 50 && wait_n < 3000) begin
      @(negedge clk);
      wait_n++;
    end
    check("rx bit 50 reached", 384'(edges4 >= 256 + 50), 384'(1));
    #2;
    rst = 1'b0;
    #1;
    check("mid-rx reset cs", spi4.CS, 1'b1);
    check("mid-rx reset sclk", spi4.SCLK, 1'b0);
    check("mid-rx reset busy", busy4, 1'b0);
    check("mid-rx reset ct", ct4, 128'h0);
    @(negedge clk);
    rst = 1'b1;
    run_job(1'b0, rnd128(), rnd256(), rnd128(), 1'b0, 1'b0, "after reset");

    check("sclk high with cs high nk4", 384'(viol4), 384'(0));
    check("sclk high with cs high nk8", 384'(viol8), 384'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
